// File: rtl/data_mem_pkg.sv
// Shared constants and decode types for the data memory with its register window.
package data_mem_pkg;

  localparam int OFS_WREG     = 0;
  localparam int OFS_CARRY    = 1;
  localparam int OFS_ZERO     = 2;
  localparam int IND_BASE     = 3;
  localparam int IND_STRIDE   = 3;
  localparam int INDC_INC_BIT = 0;

  typedef enum logic [2:0] {
    RAM,
    WREG,
    CARRY,
    ZERO,
    INDV,
    INDA,
    INDC,
    UNMAPPED
  } dec_e;

endpackage

// File: rtl/data_mem_mmio_ind_channel.sv
// One indirect-access channel: pointer plus post-increment control bit.
module ind_channel
  import data_mem_pkg::*;
#(
  parameter int PW = 9
) (
  input  logic          clk,
  input  logic          reset_bar,
  input  logic          acc,
  input  logic          wr_ptr,
  input  logic          wr_ctl,
  input  logic [PW-1:0] ptr_wdata,
  input  logic          ctl_wdata,
  output logic [PW-1:0] ptr,
  output logic          inc_en
);

  // Pointer write beats the increment; PW-bit add wraps at RAM_DEPTH.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      ptr    <= '0;
      inc_en <= 1'b0;
    end else begin
      if (wr_ptr)
        ptr <= ptr_wdata;
      else if (acc && inc_en)
        ptr <= ptr + 1'b1;
      if (wr_ctl)
        inc_en <= ctl_wdata;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Word-addressable data RAM followed by a register window (WREG, flags,
// indirect channels); one-cycle registered read.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 11,
  parameter int          RAM_DEPTH = 512,
  parameter int          NUM_IND   = 2,
  parameter logic [15:0] BAD_VAL   = 16'hDEAD
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic [DATA_W-1:0] wreg,
  input  logic              flags_we,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              carry_out,
  output logic              zero_out
);

  localparam int PW = $clog2(RAM_DEPTH);
  localparam logic [DATA_W-1:0] BAD = DATA_W'(BAD_VAL);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [PW-1:0]     ptr [NUM_IND];
  logic [NUM_IND-1:0] ctl;

  dec_e               dec;
  logic [ADDR_W-1:0]  ofs;
  logic [NUM_IND-1:0] ch_oh;
  logic [PW-1:0]      sel_ptr;
  logic               sel_ctl;
  logic [PW-1:0]      ram_addr;
  logic [DATA_W-1:0]  rdata;
  logic [NUM_IND-1:0] acc_v, wr_a, wr_c;
  logic [DATA_W-1:0]  rd_data_p1;
  logic               vld_p1;

  // Stage 0: address decode, channel select and combinational read mux
  always_comb begin
    dec     = UNMAPPED;
    ch_oh   = '0;
    sel_ptr = '0;
    sel_ctl = 1'b0;
    ofs     = addr - ADDR_W'(RAM_DEPTH);
    if (addr < ADDR_W'(RAM_DEPTH))
      dec = RAM;
    else if (ofs == ADDR_W'(OFS_WREG))
      dec = WREG;
    else if (ofs == ADDR_W'(OFS_CARRY))
      dec = CARRY;
    else if (ofs == ADDR_W'(OFS_ZERO))
      dec = ZERO;
    else begin
      for (int k = 0; k < NUM_IND; k++) begin
        if (ofs == ADDR_W'(IND_BASE + IND_STRIDE*k)) begin
          dec = INDV; ch_oh[k] = 1'b1; sel_ptr = ptr[k]; sel_ctl = ctl[k];
        end else if (ofs == ADDR_W'(IND_BASE + IND_STRIDE*k + 1)) begin
          dec = INDA; ch_oh[k] = 1'b1; sel_ptr = ptr[k]; sel_ctl = ctl[k];
        end else if (ofs == ADDR_W'(IND_BASE + IND_STRIDE*k + 2)) begin
          dec = INDC; ch_oh[k] = 1'b1; sel_ptr = ptr[k]; sel_ctl = ctl[k];
        end
      end
    end
  end

  assign ram_addr = (dec == INDV) ? sel_ptr : addr[PW-1:0];
  assign acc_v    = ((rd_en || wr_en) && dec == INDV) ? ch_oh : '0;
  assign wr_a     = (wr_en && dec == INDA) ? ch_oh : '0;
  assign wr_c     = (wr_en && dec == INDC) ? ch_oh : '0;

  always_comb begin
    rdata = BAD;
    unique case (dec)
      RAM, INDV: rdata = mem[ram_addr];
      WREG:      rdata = wreg;
      CARRY:     rdata = DATA_W'(carry_out);
      ZERO:      rdata = DATA_W'(zero_out);
      INDA:      rdata = DATA_W'(sel_ptr);
      INDC:      rdata = DATA_W'(sel_ctl);
      default:   rdata = BAD;
    endcase
  end

  for (genvar g = 0; g < NUM_IND; g++) begin : g_ch
    ind_channel #(.PW(PW)) u_ch (
      .clk       (clk),
      .reset_bar (reset_bar),
      .acc       (acc_v[g]),
      .wr_ptr    (wr_a[g]),
      .wr_ctl    (wr_c[g]),
      .ptr_wdata (in_data[PW-1:0]),
      .ctl_wdata (in_data[INDC_INC_BIT]),
      .ptr       (ptr[g]),
      .inc_en    (ctl[g])
    );
  end

  // RAM array is read combinationally above, so same-edge read returns old data.
  always_ff @(posedge clk) begin
    if (wr_en && (dec == RAM || dec == INDV))
      mem[ram_addr] <= in_data;
  end

  // A software write to a flag overrides the ALU strobe for that flag only.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
    end else begin
      if (wr_en && dec == CARRY)
        carry_out <= in_data[0];
      else if (flags_we)
        carry_out <= carry_in;
      if (wr_en && dec == ZERO)
        zero_out <= in_data[0];
      else if (flags_we)
        zero_out <= zero_in;
    end
  end

  // Stage 1: registered read data and valid
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en)
        rd_data_p1 <= rdata;
    end
  end

  assign out_data  = rd_data_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed scoreboard bench for data_mem_mmio with default parameters.
module tb_data_mem_mmio;

  localparam int B = 512;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic [10:0] addr;
  logic        rd_en, wr_en;
  logic [15:0] in_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic [15:0] wreg;
  logic        flags_we, carry_in, zero_in;
  logic        carry_out, zero_out;

  logic [15:0] model [512];
  logic [15:0] q [$];
  logic [15:0] exp_v;
  int          n_vec = 0;
  int          n_bad = 0;

  data_mem_mmio dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .addr      (addr),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .wreg      (wreg),
    .flags_we  (flags_we),
    .carry_in  (carry_in),
    .zero_in   (zero_in),
    .carry_out (carry_out),
    .zero_out  (zero_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input string t);
    @(posedge clk);
    #1;
    n_vec++;
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      assert (out_valid === 1'b1 && out_data === exp_v)
      else begin
        n_bad++;
        $error("FAIL %s: got valid=%b data=%h, expected valid=1 data=%h", t, out_valid, out_data, exp_v);
      end
    end else begin
      assert (out_valid === 1'b0)
      else begin
        n_bad++;
        $error("FAIL %s: got valid=%b, expected valid=0", t, out_valid);
      end
    end
  endtask

  task automatic acc(input string t, input int a, input logic r, input logic w,
                     input logic [15:0] d, input logic [15:0] e);
    addr    = 11'(a);
    rd_en   = r;
    wr_en   = w;
    in_data = d;
    if (r) q.push_back(e);
    tick(t);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wr(input string t, input int a, input logic [15:0] d);
    acc(t, a, 1'b0, 1'b1, d, 16'h0);
  endtask

  task automatic rd(input string t, input int a, input logic [15:0] e);
    acc(t, a, 1'b1, 1'b0, 16'h0, e);
  endtask

  task automatic chk(input string t, input logic [15:0] got, input logic [15:0] e);
    n_vec++;
    assert (got === e)
    else begin
      n_bad++;
      $error("FAIL %s: got %h, expected %h", t, got, e);
    end
  endtask

  initial begin
    reset_bar = 1'b0;
    addr = '0; rd_en = 0; wr_en = 0; in_data = '0;
    wreg = '0; flags_we = 0; carry_in = 0; zero_in = 0;
    #22;
    chk("reset out_valid", 16'(out_valid), 16'h0);
    chk("reset out_data", out_data, 16'h0);
    chk("reset carry", 16'(carry_out), 16'h0);
    chk("reset zero", 16'(zero_out), 16'h0);
    reset_bar = 1'b1;

    rd("reset INDA_0", B+4, 16'h0);
    rd("reset INDC_0", B+5, 16'h0);
    rd("reset INDA_1", B+7, 16'h0);
    rd("reset INDC_1", B+8, 16'h0);

    for (int i = 0; i < 512; i++) begin
      model[i] = 16'(i * 16'h0123) ^ 16'h5A5A;
      wr("fill", i, model[i]);
    end

    rd("unmapped 7FF", 11'h7FF, 16'hDEAD);
    rd("unmapped first", B+9, 16'hDEAD);
    wr("wr 7FF", 11'h7FF, 16'h9999);
    wr("wr first unmapped", B+9, 16'h8888);
    for (int i = 0; i < 512; i++) rd("ram intact", i, model[i]);

    wr("wr ram5", 5, 16'h1234); model[5] = 16'h1234;
    rd("rd ram5", 5, 16'h1234);
    acc("rd/wr ram5 read-first", 5, 1'b1, 1'b1, 16'hBEEF, 16'h1234); model[5] = 16'hBEEF;
    rd("reread ram5", 5, 16'hBEEF);

    wreg = 16'hC0DE;
    rd("wreg read", B+0, 16'hC0DE);
    wr("wreg write ignored", B+0, 16'h1111);
    wreg = 16'h4321;
    rd("wreg live", B+0, 16'h4321);

    wr("INDA_0=511", B+4, 16'd511);
    wr("INDC_0=1", B+5, 16'h1);
    wr("ram511", 511, 16'hA); model[511] = 16'hA;
    wr("ram0", 0, 16'hB);     model[0] = 16'hB;
    rd("INDV_0 at 511", B+3, 16'hA);
    rd("INDV_0 wrapped", B+3, 16'hB);
    rd("INDA_0 after wrap", B+4, 16'd1);

    wr("INDA_0=10", B+4, 16'd10);
    wr("INDC_0=0", B+5, 16'h0);
    wr("INDA_1=20", B+7, 16'd20);
    wr("INDC_1=1", B+8, 16'h1);
    wr("INDV_0=7", B+3, 16'd7);  model[10] = 16'd7;
    wr("INDV_1=9", B+6, 16'd9);  model[20] = 16'd9;
    rd("INDA_0 no inc", B+4, 16'd10);
    rd("INDA_1 inc", B+7, 16'd21);
    rd("ram10", 10, 16'd7);
    rd("ram20", 20, 16'd9);

    wr("INDC_1 wide", B+8, 16'hFFFE);
    rd("INDC_1 bit0 only", B+8, 16'h0);
    wr("INDA_0 wide", B+4, 16'hFE05);
    rd("INDA_0 truncated", B+4, 16'h0005);

    wr("INDA_0=30", B+4, 16'd30);
    wr("INDC_0=1 again", B+5, 16'hFFFF);
    rd("INDC_0 read", B+5, 16'h1);
    acc("INDV_0 rd/wr", B+3, 1'b1, 1'b1, 16'h7777, model[30]); model[30] = 16'h7777;
    rd("INDA_0 single inc", B+4, 16'd31);
    rd("ram30", 30, 16'h7777);
    wr("INDA_0=50", B+4, 16'd50);
    rd("INDV_0 at 50", B+3, model[50]);
    wr("INDA_0=100", B+4, 16'd100);
    rd("INDA_0 written", B+4, 16'd100);

    flags_we = 1; carry_in = 1; zero_in = 0;
    wr("carry sw prio", B+1, 16'h0);
    chk("carry sw prio", 16'(carry_out), 16'h0);
    carry_in = 0; zero_in = 1;
    tick("flags_we zero");
    flags_we = 0;
    chk("zero from alu", 16'(zero_out), 16'h1);
    wr("carry=FFFE", B+1, 16'hFFFE);
    chk("carry bit0", 16'(carry_out), 16'h0);
    rd("zero read", B+2, 16'h1);
    wr("zero=0", B+2, 16'h0);
    chk("zero sw", 16'(zero_out), 16'h0);
    flags_we = 1; carry_in = 1; zero_in = 0;
    wr("zero sw prio", B+2, 16'h1);
    flags_we = 0;
    chk("zero sw prio", 16'(zero_out), 16'h1);
    chk("carry alu same cycle", 16'(carry_out), 16'h1);
    rd("carry read", B+1, 16'h1);

    addr = 11'(5); rd_en = 1'b1;
    #2;
    reset_bar = 1'b0;
    #1;
    chk("async rst valid", 16'(out_valid), 16'h0);
    chk("async rst data", out_data, 16'h0);
    chk("async rst carry", 16'(carry_out), 16'h0);
    chk("async rst zero", 16'(zero_out), 16'h0);
    @(posedge clk);
    #1;
    chk("held rst valid", 16'(out_valid), 16'h0);
    rd_en = 1'b0;
    reset_bar = 1'b1;
    rd("post rst INDA_0", B+4, 16'h0);
    rd("post rst INDC_0", B+5, 16'h0);
    rd("post rst INDA_1", B+7, 16'h0);
    rd("post rst ram30", 30, 16'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
